// File: rtl/bm_log_result_serializer_if.sv
// Bundles the frame-input handshake, the result-word bus, the output
// beat stream and the signature/frame-count observation signals of
// bm_log_result_serializer.
//   master : frame producer / beat consumer (drives in_valid, res1..res8,
//            out_ready, sig_clr)
//   slave  : the serializer (drives in_ready, out_valid, out_data, out_idx,
//            out_last, signature, frame_count)
interface bm_log_result_serializer_if #(
  parameter int unsigned BITS = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] res1, res2, res3, res4, res5, res6, res7, res8;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic [2:0]      out_idx;
  logic            out_last;
  logic            sig_clr;
  logic [BITS-1:0] signature;
  logic [15:0]     frame_count;

  modport master (
    output in_valid, res1, res2, res3, res4, res5, res6, res7, res8,
    output out_ready, sig_clr,
    input  in_ready, out_valid, out_data, out_idx, out_last,
    input  signature, frame_count
  );

  modport slave (
    input  in_valid, res1, res2, res3, res4, res5, res6, res7, res8,
    input  out_ready, sig_clr,
    output in_ready, out_valid, out_data, out_idx, out_last,
    output signature, frame_count
  );
endinterface

// File: rtl/bm_log_result_serializer.sv
// Capture stage for the bitwise-logic microbenchmark. Accepts one frame of
// eight result words, replays the words enabled by WORD_MASK one per beat
// (tagged with word index), folds every accepted beat into a rotate-XOR
// signature and counts completed frames.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave view of bm_log_result_serializer_if (frame input,
//              beat stream, sig_clr, signature, frame_count)
module bm_log_result_serializer #(
  parameter int unsigned BITS      = 32,
  parameter logic [7:0]  WORD_MASK = 8'hCF
) (
  input logic                   clock,
  input logic                   reset_n,
  bm_log_result_serializer_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  logic [BITS-1:0] r_words [8];
  logic [2:0]      r_idx;
  logic            r_valid;
  logic            r_last;
  logic [BITS-1:0] r_data;
  logic [BITS-1:0] r_sig;
  logic [15:0]     r_fcnt;

  logic [BITS-1:0] w_res [8];
  logic            w_beat;
  logic [2:0]      w_first;
  logic [2:0]      w_next;
  logic            w_first_last;
  logic            w_next_last;

  // Lowest enabled index strictly above cur (cur itself if none).
  function automatic logic [2:0] next_en(input logic [2:0] cur);
    logic [2:0] n;
    logic       found;
    n     = cur;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && (i > 32'(cur)) && WORD_MASK[i[2:0]]) begin
        n     = i[2:0];
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [2:0] first_en();
    logic [2:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && WORD_MASK[i[2:0]]) begin
        n     = i[2:0];
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic none_above(input logic [2:0] cur);
    logic f;
    f = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((i > 32'(cur)) && WORD_MASK[i[2:0]]) f = 1'b0;
    end
    return f;
  endfunction

  assign w_res[0] = bus.res1;
  assign w_res[1] = bus.res2;
  assign w_res[2] = bus.res3;
  assign w_res[3] = bus.res4;
  assign w_res[4] = bus.res5;
  assign w_res[5] = bus.res6;
  assign w_res[6] = bus.res7;
  assign w_res[7] = bus.res8;

  assign w_beat       = r_valid && bus.out_ready;
  assign w_first      = first_en();
  assign w_next       = next_en(r_idx);
  assign w_first_last = none_above(w_first);
  assign w_next_last  = none_above(w_next);

  // out_data/out_last are registered: the word and last flag for the next
  // beat are looked up one edge early, at capture or on the advancing beat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      for (int unsigned i = 0; i < 8; i++) r_words[i] <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_sig   <= '0;
      r_fcnt  <= '0;
    end else begin
      // Clear is applied before the fold, so a coincident beat lands as-is.
      if (bus.sig_clr) begin
        r_sig <= w_beat ? r_data : '0;
      end else if (w_beat) begin
        r_sig <= {r_sig[BITS-2:0], r_sig[BITS-1]} ^ r_data;
      end

      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < 8; i++) r_words[i] <= w_res[i];
            if (WORD_MASK == '0) begin
              r_fcnt <= r_fcnt + 16'd1;
            end else begin
              r_idx   <= w_first;
              r_data  <= w_res[w_first];
              r_last  <= w_first_last;
              r_valid <= 1'b1;
              r_state <= SEND;
            end
          end
        end
        SEND: begin
          if (w_beat) begin
            if (r_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_data  <= '0;
              r_last  <= 1'b0;
              r_fcnt  <= r_fcnt + 16'd1;
            end else begin
              r_idx  <= w_next;
              r_data <= r_words[w_next];
              r_last <= w_next_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = r_valid;
  assign bus.out_data    = r_data;
  assign bus.out_idx     = r_idx;
  assign bus.out_last    = r_last;
  assign bus.signature   = r_sig;
  assign bus.frame_count = r_fcnt;

endmodule
